// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous data RAM: FSM state encoding and
// the byte-lane helper.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sync.sv
// Single-port synchronous data RAM with per-byte write enables, a registered
// read with a valid strobe, and a clear sweep that runs after reset or on request.
module ram_sync
    import ram_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                DEPTH   = 1 << ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       req,
    input  logic                       WE,
    input  logic [ADDR_W-1:0]          dir,
    input  logic [bytes(DATA_W)-1:0]   be,
    input  logic [DATA_W-1:0]          Dato,
    output logic [DATA_W-1:0]          Q,
    output logic                       q_valid,
    output logic                       ready,
    output state_t                     state
);

    localparam int                NB        = bytes(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_d;

    logic              accept;
    logic              in_range;
    logic              rd_fire;
    logic              wr_fire;
    logic [DATA_W-1:0] rd_data;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;

    // Handshake: an operation is taken at a rising edge iff req && ready && !clr.
    // ready is high only in IDLE; requests while ready is low are dropped, and a
    // clr request in IDLE wins over a simultaneous req.
    assign ready   = (state_q == ST_IDLE);
    assign state   = state_q;
    assign accept  = req && ready && !clr;
    assign rd_fire = accept && !WE;
    assign wr_fire = accept && WE && in_range;

    generate
        if (DEPTH >= (1 << ADDR_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_partial
            assign in_range = (32'(dir) < 32'(DEPTH));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            clr_ptr <= clr_ptr_d;
        end
    end

    // The sweep owns the write port; datapath writes only happen in IDLE anyway.
    always_comb begin
        mem_we    = wr_fire;
        mem_addr  = dir;
        mem_wdata = Dato;
        mem_be    = be;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr;
            mem_wdata = CLR_VAL;
            mem_be    = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = in_range ? mem[dir] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= rd_fire;
            if (rd_fire) begin
                Q <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: directed steps plus a randomized phase,
// checked against a word-array reference model and an expected-read queue.
module tb_ram_sync;
    import ram_pkg::*;

    localparam int          DEPTH_A = 32;
    localparam int          DEPTH_B = 20;
    localparam logic [31:0] CLR     = 32'h0;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance a: full depth
    logic        clr, req, we;
    logic [4:0]  dir;
    logic [3:0]  be;
    logic [31:0] dato;
    logic [31:0] q;
    logic        q_valid, ready;
    state_t      a_state;

    // instance b: DEPTH=20, exercises out-of-range addresses
    logic        b_clr, b_req, b_we;
    logic [4:0]  b_dir;
    logic [3:0]  b_be;
    logic [31:0] b_dato;
    logic [31:0] b_q;
    logic        b_q_valid, b_ready;
    state_t      b_state;

    ram_sync #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH_A), .CLR_VAL(CLR)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .req(req), .WE(we), .dir(dir), .be(be),
        .Dato(dato), .Q(q), .q_valid(q_valid), .ready(ready), .state(a_state)
    );

    ram_sync #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH_B), .CLR_VAL(CLR)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .req(b_req), .WE(b_we), .dir(b_dir), .be(b_be),
        .Dato(b_dato), .Q(b_q), .q_valid(b_q_valid), .ready(b_ready), .state(b_state)
    );

    // reference model and scoreboard
    logic [31:0] m_mem [0:DEPTH_A-1];
    logic [31:0] m_q;
    logic        m_qv;
    int          clear_left;
    logic [31:0] exp_q [$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    // One clock: apply the model rules for the inputs now on the pins,
    // step past the edge, then compare instance a against the model.
    task automatic tick();
        logic [31:0] mask;
        logic [31:0] exp_d;
        if (clear_left > 0) begin
            clear_left--;
            m_qv = 1'b0;
        end else if (clr) begin
            clear_left = DEPTH_A;
            for (int i = 0; i < DEPTH_A; i++) m_mem[i] = CLR;
            m_qv = 1'b0;
        end else if (req && we) begin
            mask       = be_mask(be);
            m_mem[dir] = (m_mem[dir] & ~mask) | (dato & mask);
            m_qv       = 1'b0;
        end else if (req) begin
            m_q  = m_mem[dir];
            m_qv = 1'b1;
            exp_q.push_back(m_mem[dir]);
        end else begin
            m_qv = 1'b0;
        end
        @(posedge clk);
        #1;
        check("ready", 32'(ready), 32'(clear_left == 0));
        check("state", 32'(a_state), 32'(clear_left == 0 ? ST_IDLE : ST_CLEAR));
        check("q_valid", 32'(q_valid), 32'(m_qv));
        if (q_valid) begin
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check("q_data", q, exp_d);
            end else begin
                check("q_spurious", 32'(q_valid), 32'h0);
            end
        end
        check("q_hold", q, m_q);
        check("sb_pending", 32'(exp_q.size()), 32'h0);
    endtask

    // driver tasks
    task automatic drive_idle();
        clr = 1'b0; req = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        clr = 1'b0; req = 1'b1; we = 1'b1; dir = a; dato = d; be = b;
        tick();
        req = 1'b0;
    endtask

    task automatic drive_read(input logic [4:0] a);
        clr = 1'b0; req = 1'b1; we = 1'b0; dir = a;
        tick();
        req = 1'b0;
    endtask

    task automatic b_op(input logic w, input logic [4:0] a, input logic [31:0] d);
        b_req = 1'b1; b_we = w; b_dir = a; b_dato = d; b_be = 4'hF;
        tick();
        b_req = 1'b0;
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, hold for 'hold' edges.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        check("rst_q", q, 32'h0);
        check("rst_q_valid", 32'(q_valid), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_state", 32'(a_state), 32'(ST_CLEAR));
        repeat (hold) @(posedge clk);
        #1;
        rst        = 1'b0;
        clear_left = DEPTH_A;
        m_q        = '0;
        m_qv       = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH_A; i++) m_mem[i] = CLR;
    endtask

    task automatic sweep_len(input string tag);
        int a_n;
        int b_n;
        a_n = 0;
        b_n = 0;
        for (int n = 1; n <= 100; n++) begin
            drive_idle();
            if (b_ready && b_n == 0) b_n = n;
            if (ready) begin
                a_n = n;
                break;
            end
        end
        check({tag, "_a"}, 32'(a_n), 32'(DEPTH_A));
        check({tag, "_b"}, 32'(b_n), 32'(DEPTH_B));
    endtask

    initial begin
        int low;
        clr = 0; req = 0; we = 0; dir = 0; be = 0; dato = 0;
        b_clr = 0; b_req = 0; b_we = 0; b_dir = 0; b_be = 0; b_dato = 0;
        m_q = 0; m_qv = 0; clear_left = 0;
        #2;

        // reset release and initial sweep
        do_reset(2);
        sweep_len("sweep_init");
        drive_read(5'd0);  check("t1_rd0", q, 32'h0);
        drive_read(5'd17); check("t1_rd17", q, 32'h0);
        drive_read(5'd31); check("t1_rd31", q, 32'h0);
        drive_idle();

        // out-of-range on the DEPTH=20 instance
        check("b_state", 32'(b_state), 32'(ST_IDLE));
        b_op(1'b1, 5'd25, 32'hFFFFFFFF);
        b_op(1'b1, 5'd19, 32'h12345678);
        b_op(1'b0, 5'd25, 32'h0);
        check("b_oor_qv", 32'(b_q_valid), 32'h1);
        check("b_oor_q", b_q, 32'h0);
        b_op(1'b0, 5'd19, 32'h0);
        check("b_last_q", b_q, 32'h12345678);
        drive_idle();
        check("b_qv_low", 32'(b_q_valid), 32'h0);

        // full-word write then read
        drive_write(5'd5, 32'hDEADBEEF, 4'hF);
        drive_read(5'd5);
        check("t2_q", q, 32'hDEADBEEF);
        check("t2_qv", 32'(q_valid), 32'h1);
        drive_idle();
        check("t2_qv_pulse", 32'(q_valid), 32'h0);

        // byte-enable merge
        drive_write(5'd5, 32'h11223344, 4'b0101);
        drive_read(5'd5);
        check("t3_q", q, 32'hDE22BE44);

        // clr with a simultaneous write; writes during the sweep are dropped
        clr = 1'b1; req = 1'b1; we = 1'b1; dir = 5'd5; dato = 32'hFFFFFFFF; be = 4'hF;
        tick();
        low = ready ? 0 : 1;
        clr = 1'b0;
        for (int n = 0; n < 100 && !ready; n++) begin
            tick();
            if (!ready) low++;
        end
        check("t4_ready_low", 32'(low), 32'd32);
        req = 1'b0;
        drive_read(5'd5);
        check("t4_q", q, 32'h0);

        // back-to-back reads
        drive_write(5'd1, 32'd1, 4'hF);
        drive_write(5'd2, 32'd2, 4'hF);
        drive_write(5'd3, 32'd3, 4'hF);
        for (int k = 1; k <= 3; k++) begin
            drive_read(5'(k));
            check("t5_q", q, 32'(k));
            check("t5_qv", 32'(q_valid), 32'h1);
        end
        drive_idle();

        // reset the cycle after a read, then reset at sweep cycle 10
        drive_write(5'd7, 32'hA5A5A5A5, 4'hF);
        drive_read(5'd7);
        check("t6_pre_q", q, 32'hA5A5A5A5);
        do_reset(1);
        repeat (10) drive_idle();
        do_reset(1);
        sweep_len("sweep_restart");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            clr  = ($urandom_range(0, 59) == 0);
            req  = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1);
            dir  = 5'($urandom_range(0, DEPTH_A - 1));
            be   = 4'($urandom_range(0, 15));
            dato = $urandom;
            tick();
        end
        clr = 1'b0;
        req = 1'b0;
        repeat (40) drive_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
